// File: rtl/regbank8_if.sv
// Bus bundle for the eight-entry register bank: decoder write enables,
// registered read port, clear sweep handshake and sticky error flag.
interface regbank8_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       we;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       raddr;
    logic [WIDTH-1:0] rdata;
    logic             clr_req;
    logic             busy;
    logic             err_clr;
    logic             err;

    modport master (
        output we, wdata, raddr, clr_req, err_clr,
        input  rdata, busy, err
    );

    modport slave (
        input  we, wdata, raddr, clr_req, err_clr,
        output rdata, busy, err
    );
endinterface

// File: rtl/regbank8.sv
// Eight-entry register bank fed by one-hot decoder enables, with a registered
// read port, an eight-cycle clear sweep and a sticky multi-hot error flag.
module regbank8 #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    regbank8_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic [WIDTH-1:0] entry_reg [8];
    logic [WIDTH-1:0] rdata_reg;
    logic             err_reg;

    logic       multi_hot;
    logic [7:0] wr_en;
    logic [7:0] clr_en;

    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign multi_hot = |(bus.we & (bus.we - 8'd1));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_entry_ctl
            assign wr_en[gi]  = (state_reg == ST_IDLE) && !multi_hot && bus.we[gi];
            assign clr_en[gi] = (state_reg == ST_CLEAR) && (ptr_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_next = ST_CLEAR;
                    ptr_next   = 3'd0;
                end
            end
            ST_CLEAR: begin
                ptr_next = ptr_reg + 3'd1;
                if (ptr_reg == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Clear and write never coincide: clr_en needs CLEAR, wr_en needs IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (rst || clr_en[i]) begin
                entry_reg[i] <= '0;
            end else if (wr_en[i]) begin
                entry_reg[i] <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= entry_reg[bus.raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (multi_hot) begin
            err_reg <= 1'b1;
        end else if (bus.err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;
    assign bus.busy  = (state_reg == ST_CLEAR);
endmodule

// File: tb/tb_regbank8.sv
// Directed bench for regbank8: vector table for write/read/error behaviour,
// hand sequences for the clear sweep and reset during a sweep.
module tb_regbank8;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regbank8_if #(.WIDTH(WIDTH)) bus ();

    regbank8 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       we;
        logic [WIDTH-1:0] wdata;
        logic [2:0]       raddr;
        logic             err_clr;
        logic [WIDTH-1:0] exp_rdata;
        logic             exp_busy;
        logic             exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] we, input logic [7:0] wdata,
                                input logic [2:0] raddr, input logic err_clr,
                                input logic [7:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.wdata = wdata; v.raddr = raddr; v.err_clr = err_clr;
        v.exp_rdata = exp_rdata; v.exp_busy = 1'b0; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        bus.we = 8'h00; bus.wdata = '0; bus.raddr = 3'd0;
        bus.clr_req = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic fill(input logic [7:0] value);
        for (int n = 0; n < 8; n++) begin
            bus.we = 8'h01 << n;
            bus.wdata = value;
            tick();
        end
        bus.we = 8'h00;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.raddr = 3'(i);
            tick();
            check($sformatf("%s_rd%0d", tag, i), 32'(bus.rdata), 32'h0);
        end
    endtask

    // Counts cycles with busy high, starting right after the clr_req edge.
    task automatic measure_busy(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 20) begin
            cycles++;
            tick();
            if (!bus.busy) begin
                bus.we = 8'h00;
                bus.clr_req = 1'b0;
            end
        end
    endtask

    initial begin
        int cycles;
        checks = 0;
        failures = 0;
        idle_inputs();

        rst = 1'b1;
        tick();
        tick();
        check("reset_rdata", 32'(bus.rdata), 32'h0);
        check("reset_busy",  32'(bus.busy),  32'h0);
        check("reset_err",   32'(bus.err),   32'h0);
        rst = 1'b0;
        read_all_zero("reset");

        for (int n = 0; n < 8; n++) add(8'h01 << n, 8'hA0 + 8'(n), 3'(n), 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 8; n++) add(8'h00, 8'h00, 3'(n), 1'b0, 8'hA0 + 8'(n), 1'b0);
        add(8'h08, 8'h11, 3'd0, 1'b0, 8'hA0, 1'b0);
        add(8'h08, 8'h22, 3'd3, 1'b0, 8'h11, 1'b0);
        add(8'h00, 8'h00, 3'd3, 1'b0, 8'h22, 1'b0);
        add(8'h05, 8'hFF, 3'd0, 1'b0, 8'hA0, 1'b1);
        add(8'h00, 8'h00, 3'd2, 1'b0, 8'hA2, 1'b1);
        add(8'h03, 8'hFF, 3'd0, 1'b1, 8'hA0, 1'b1);
        add(8'h00, 8'h00, 3'd1, 1'b1, 8'hA1, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0, 8'hA0, 1'b0);

        foreach (vecs[i]) begin
            bus.we = vecs[i].we;
            bus.wdata = vecs[i].wdata;
            bus.raddr = vecs[i].raddr;
            bus.err_clr = vecs[i].err_clr;
            tick();
            check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_err", i),   32'(bus.err),   32'(vecs[i].exp_err));
            $display("vec %0d we=%02h wdata=%02h raddr=%0d err_clr=%0b -> rdata=%02h err=%0b",
                     i, vecs[i].we, vecs[i].wdata, vecs[i].raddr, vecs[i].err_clr,
                     bus.rdata, bus.err);
        end
        idle_inputs();

        // Clear sweep with writes and clr_req held during the sweep.
        fill(8'h5A);
        bus.clr_req = 1'b1;
        tick();
        check("clr_busy_rise", 32'(bus.busy), 32'h1);
        bus.we = 8'h01;
        bus.wdata = 8'hEE;
        measure_busy(cycles);
        check("clr_busy_cycles", 32'(cycles), 32'd8);
        check("clr_err", 32'(bus.err), 32'h0);
        $display("clear sweep: busy cycles=%0d", cycles);
        read_all_zero("clr");

        // Reset three cycles into a sweep.
        fill(8'h5A);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_busy_before", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_rdata", 32'(bus.rdata), 32'h0);
        $display("reset mid-sweep: busy=%0b", bus.busy);
        read_all_zero("midrst");
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        measure_busy(cycles);
        check("restart_busy_cycles", 32'(cycles), 32'd8);
        $display("restarted sweep: busy cycles=%0d", cycles);

        // First write after a sweep lands and reads back.
        bus.we = 8'h10;
        bus.wdata = 8'h3C;
        bus.raddr = 3'd4;
        tick();
        bus.we = 8'h00;
        tick();
        check("post_clr_write", 32'(bus.rdata), 32'h3C);
        $display("post-sweep write: rdata=%02h", bus.rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
